// File: rtl/stable_match_check.sv
// stable_match_check: walks every man's preference list one entry per cycle and
// looks for a blocking pair in a finished woman-indexed matching.
// Optional build macro: STABLE_MATCH_CHECK_FULL_SCAN_EN -- when defined the scan
// never exits early and bp_count tallies every blocking pair (saturating).

package stable_match_check_pkg;
    // Ceiling log2, never below 1 so that derived vector widths stay legal.
    function automatic int log2(input int x);
        int r;
        r = 0;
        while ((1 << r) < x) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

module stable_match_check
    import stable_match_check_pkg::*;
#(
    parameter int M  = 8,
    parameter int W  = 8,
    parameter int Km = 8,
    parameter int Kw = 8,
    localparam int logM  = log2(M),
    localparam int logW  = log2(W),
    localparam int logKm = log2(Km),
    localparam int logKw = log2(Kw),
    localparam int CNT_W = $clog2(M*Km+1)
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [M*Km*logW-1:0]      mPref,
    input  logic [W*M*logKw-1:0]      wRank,
    input  logic [W*logM-1:0]         matchList,
    input  logic [W-1:0]              wMatched,
    output logic                      busy,
    output logic                      done,
    output logic                      stable,
    output logic [logM-1:0]           bp_m,
    output logic [logW-1:0]           bp_w,
    output logic [CNT_W-1:0]          bp_count
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [logM-1:0]  MLAST = logM'(M-1);
    localparam logic [logKm-1:0] KLAST = logKm'(Km-1);

    state_t                 state_q, state_d;
    logic [logM-1:0]        m_q, m_d;
    logic [logKm-1:0]       k_q, k_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [logM-1:0]        bpm_q, bpm_d;
    logic [logW-1:0]        bpw_q, bpw_d;
    logic                   found_q, found_d;
    logic                   stable_q, stable_d;

    logic [logW-1:0]        cur_w;
    logic [logM-1:0]        cur_p;
    logic [logKw-1:0]       rank_new, rank_cur;
    logic                   hit, blocking, advance, last, leave;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Evaluate the (man, woman) pair selected by the scan indices.
    always_comb begin
        cur_w    = mPref[logW*(int'(m_q)*Km + int'(k_q)) +: logW];
        cur_p    = matchList[logM*int'(cur_w) +: logM];
        rank_new = wRank[logKw*(int'(cur_w)*M + int'(m_q)) +: logKw];
        rank_cur = wRank[logKw*(int'(cur_w)*M + int'(cur_p)) +: logKw];
        hit      = wMatched[cur_w] && (cur_p == m_q);
        // An unmatched woman prefers anyone; otherwise strict rank improvement.
        blocking = !hit && (!wMatched[cur_w] || (rank_new < rank_cur));
        // A man is finished on reaching his partner or exhausting his list.
        advance  = hit || (k_q == KLAST);
        last     = advance && (m_q == MLAST);
`ifdef STABLE_MATCH_CHECK_FULL_SCAN_EN
        leave    = last;
`else
        leave    = last || blocking;
`endif
    end

    // Next-state and result bookkeeping for the IDLE/SCAN/DONE controller.
    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        bpm_d    = bpm_q;
        bpw_d    = bpw_q;
        found_d  = found_q;
        stable_d = stable_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d  = SCAN;
                    m_d      = '0;
                    k_d      = '0;
                    cnt_d    = '0;
                    bpm_d    = '0;
                    bpw_d    = '0;
                    found_d  = 1'b0;
                    stable_d = 1'b0;
                end
            end
            SCAN: begin
                if (blocking) begin
                    if (!found_q) begin
                        bpm_d   = m_q;
                        bpw_d   = cur_w;
                        found_d = 1'b1;
                    end
                    cnt_d = sat_inc(cnt_q);
                end
                if (advance) begin
                    m_d = m_q + logM'(1);
                    k_d = '0;
                end else begin
                    k_d = k_q + logKm'(1);
                end
                if (leave) begin
                    state_d  = DONE;
                    stable_d = !(found_q || blocking);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset returns everything to the idle values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            m_q      <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            bpm_q    <= '0;
            bpw_q    <= '0;
            found_q  <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            bpm_q    <= bpm_d;
            bpw_q    <= bpw_d;
            found_q  <= found_d;
            stable_q <= stable_d;
        end
    end

    assign busy     = (state_q == SCAN);
    assign done     = (state_q == DONE);
    assign stable   = stable_q;
    assign bp_m     = bpm_q;
    assign bp_w     = bpw_q;
    assign bp_count = cnt_q;

endmodule

// File: tb/tb_stable_match_check.sv
// Scoreboard bench for stable_match_check with M=W=Km=2, Kw=4.
module tb_stable_match_check;

`ifdef STABLE_MATCH_CHECK_FULL_SCAN_EN
    localparam bit FULL = 1'b1;
`else
    localparam bit FULL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] mPref;
    logic [7:0] wRank;
    logic [1:0] matchList;
    logic [1:0] wMatched;
    logic       busy, done, stable;
    logic [0:0] bp_m, bp_w;
    logic [2:0] bp_count;

    stable_match_check #(.M(2), .W(2), .Km(2), .Kw(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mPref(mPref), .wRank(wRank), .matchList(matchList), .wMatched(wMatched),
        .busy(busy), .done(done), .stable(stable),
        .bp_m(bp_m), .bp_w(bp_w), .bp_count(bp_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int stb;
        int bm;
        int bw;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor: every done pulse consumes the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", cyc, e.due);
                chk("busy_at_done", busy, 0);
                chk("stable", stable, e.stb);
                chk("bp_m", bp_m, e.bm);
                chk("bp_w", bp_w, e.bw);
                chk("bp_count", bp_count, e.cnt);
            end
        end
    end

    // Apply inputs, raise start for one edge, push the expected result.
    task automatic kick(input logic [3:0] mp, input logic [7:0] wr, input logic [1:0] ml,
                        input logic [1:0] wm, input int lat, input int stb,
                        input int bm, input int bw, input int cnt);
        exp_t e;
        mPref = mp; wRank = wr; matchList = ml; wMatched = wm;
        start = 1'b1;
        e.due = cyc + lat; e.stb = stb; e.bm = bm; e.bw = bw; e.cnt = cnt;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int stb);
        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            chk("timeout_waiting_done", 0, 1);
            q.delete();
        end
        @(negedge clk);
        chk("stable_hold", stable, stb);
        chk("busy_idle", busy, 0);
    endtask

    task automatic run(input logic [3:0] mp, input logic [7:0] wr, input logic [1:0] ml,
                       input logic [1:0] wm, input int lat, input int stb,
                       input int bm, input int bw, input int cnt);
        kick(mp, wr, ml, wm, lat, stb, bm, bw, cnt);
        chk("busy_scan", busy, 1);
        wait_idle(stb);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        mPref = '0; wRank = '0; matchList = '0; wMatched = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stable", stable, 0);
        chk("rst_bp_m", bp_m, 0);
        chk("rst_bp_w", bp_w, 0);
        chk("rst_bp_count", bp_count, 0);
        rst = 1'b0;
        @(negedge clk);

        // T1: everyone's first choice is the partner -> stable, 2 evaluations.
        run(4'b0110, 8'h00, 2'b10, 2'b11, 3, 1, 0, 0, 0);
        // T2: (m0,w1) blocks on the first evaluation.
        run(4'b0101, 8'b01_00_00_00, 2'b10, 2'b11, FULL ? 4 : 2, 0, 0, 1, 1);
        // T3: w1 unmatched (its matchList entry is ignored) -> (1,1) blocks.
        run(4'b0110, 8'b11_00_01_00, 2'b00, 2'b01, FULL ? 4 : 3, 0, 1, 1, 1);
        // T4: nobody matched, every pair blocks.
        run(4'b1001, 8'h00, 2'b00, 2'b00, FULL ? 5 : 2, 0, 0, 1, FULL ? 4 : 1);
        // T6: unsigned ranks, 1 < 2 on w0 -> (0,0) blocks.
        run(4'b0110, 8'b11_11_10_01, 2'b01, 2'b11, FULL ? 5 : 2, 0, 0, 0, 1);

        // T5: equal ranks never block, worst-case length; extra start in SCAN is ignored.
        kick(4'b0110, 8'b11_11_10_10, 2'b01, 2'b11, 5, 1, 0, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_ignored_start", busy, 1);
        wait_idle(1);

        // Reset mid-scan aborts the run and returns to reset values.
        kick(4'b1001, 8'h00, 2'b00, 2'b00, FULL ? 5 : 2, 0, 0, 1, FULL ? 4 : 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_stable", stable, 0);
        chk("midrst_bp_m", bp_m, 0);
        chk("midrst_bp_w", bp_w, 0);
        chk("midrst_bp_count", bp_count, 0);
        rst = 1'b0;
        q.delete();
        repeat (6) @(negedge clk);
        run(4'b0110, 8'h00, 2'b10, 2'b11, 3, 1, 0, 0, 0);

        // Back-to-back: start held in the DONE cycle of T2 launches T1.
        kick(4'b0101, 8'b01_00_00_00, 2'b10, 2'b11, FULL ? 4 : 2, 0, 0, 1, 1);
        begin
            int n;
            n = 0;
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_first_done_seen", done, 1);
        end
        kick(4'b0110, 8'h00, 2'b10, 2'b11, 3, 1, 0, 0, 0);
        chk("b2b_busy", busy, 1);
        chk("b2b_bp_count_cleared", bp_count, 0);
        chk("b2b_bp_w_cleared", bp_w, 0);
        wait_idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
